adder_arbiter: RTL and testbench

Round-robin scheduler that shares one `adder` instance among NUM_REQ requesters, each submitting a LENGTH-element vector for summation. It accepts one job at a time over a valid/ready request channel and sequences the adder's `sum_en`/`sum_done` protocol. It returns the result, tagged with the requester index, over a valid/ready response channel. It sits between the clients and the adder datapath.

---
 rtl/adder_pkg.sv | 16 +
 rtl/adder.sv | 72 +++++++
 rtl/adder_arbiter.sv | 130 +++++++++++++
 tb/tb_adder_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared types and constants for the adder arbiter slice.
//   state_e        - arbiter FSM states (IDLE, RUN, RESP)
//   SUM_PARALLEL   - adder sums the whole vector combinationally
//   SUM_SEQUENTIAL - adder accumulates one element per cycle
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP
    } state_e;

    localparam int SUM_PARALLEL   = 0;
    localparam int SUM_SEQUENTIAL = 1;

endpackage

// File: rtl/adder.sv
// adder: sums a LENGTH-element operand vector under a sum_en/sum_done handshake.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   sum_en      - start/continue summation; dropping it clears pointer and done
//   data        - LENGTH x DATA_WIDTH operand vector
//   sum_result  - $clog2(LENGTH)+DATA_WIDTH bit result
//   sum_done    - result valid
// SUM_METHOD 0 sums combinationally and reports done in the same cycle.
// SUM_METHOD 1 adds one element per cycle into an accumulator that is never
// cleared except by reset, so consecutive jobs see a running total.
module adder
    import adder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LENGTH     = 8,
    parameter int SUM_METHOD = SUM_SEQUENTIAL,
    localparam int SW        = $clog2(LENGTH) + DATA_WIDTH,
    localparam int PW        = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sum_en,
    input  logic [LENGTH-1:0][DATA_WIDTH-1:0] data,
    output logic [SW-1:0]                     sum_result,
    output logic                              sum_done
);

    if (SUM_METHOD == SUM_PARALLEL) begin : g_par
        logic [SW-1:0] sum;
        logic          unused;
        assign unused = clk ^ rst;
        always_comb begin
            sum = '0;
            for (int i = 0; i < LENGTH; i++) sum = sum + SW'(data[i]);
        end
        assign sum_result = sum;
        assign sum_done   = sum_en;
    end else if (SUM_METHOD == SUM_SEQUENTIAL) begin : g_seq
        logic [PW-1:0] ptr_q, ptr_d;
        logic          done_q, done_d;
        logic [SW-1:0] acc_q, acc_d;
        always_comb begin
            ptr_d  = ptr_q;
            done_d = done_q;
            acc_d  = acc_q;
            if (!sum_en) begin
                ptr_d  = '0;
                done_d = 1'b0;
            end else if (!done_q) begin
                acc_d  = acc_q + SW'(data[ptr_q]);
                ptr_d  = (ptr_q == PW'(LENGTH - 1)) ? '0 : ptr_q + 1'b1;
                done_d = (ptr_q == PW'(LENGTH - 1));
            end
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ptr_q  <= '0;
                done_q <= 1'b0;
                acc_q  <= '0;
            end else begin
                ptr_q  <= ptr_d;
                done_q <= done_d;
                acc_q  <= acc_d;
            end
        end
        assign sum_result = acc_q;
        assign sum_done   = done_q;
    end else begin : g_bad
        $error("adder: SUM_METHOD must be 0 or 1");
    end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin scheduler sharing one adder among NUM_REQ requesters.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (also resets the adder)
//   req_valid  - per-requester job request
//   req_data   - per-requester LENGTH x DATA_WIDTH operand vector
//   req_ready  - one-hot acceptance pulse, only in IDLE
//   rsp_valid  - result available (RESP state)
//   rsp_ready  - consumer accepts the result
//   rsp_id     - requester index owning the result
//   rsp_sum    - full-width sum, no truncation
//   busy       - high whenever the FSM is not IDLE
module adder_arbiter
    import adder_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LENGTH     = 8,
    parameter int SUM_METHOD = SUM_SEQUENTIAL,
    localparam int IDW       = $clog2(NUM_REQ),
    localparam int SW        = $clog2(LENGTH) + DATA_WIDTH
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NUM_REQ-1:0]                             req_valid,
    input  logic [NUM_REQ-1:0][LENGTH-1:0][DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                             req_ready,
    output logic                                           rsp_valid,
    input  logic                                           rsp_ready,
    output logic [IDW-1:0]                                 rsp_id,
    output logic [SW-1:0]                                  rsp_sum,
    output logic                                           busy
);

    state_e                             state_q, state_d;
    logic [IDW-1:0]                     last_q, last_d;
    logic [LENGTH-1:0][DATA_WIDTH-1:0]  opnd_q, opnd_d;
    logic [SW-1:0]                      rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0]                     rsp_id_q, rsp_id_d;
    logic [SW-1:0]                      base_q, base_d;
    logic [IDW-1:0]                     grant;
    logic                               sum_en;
    logic [SW-1:0]                      sum_result;
    logic                               sum_done;

    // First set bit strictly after last, wrapping; scanning from the far end
    // lets the nearest candidate overwrite the others.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [IDW-1:0] last);
        int j;
        rr_pick = last;
        for (int i = NUM_REQ; i >= 1; i--) begin
            j = (int'(last) + i) % NUM_REQ;
            if (v[IDW'(j)]) rr_pick = IDW'(j);
        end
    endfunction

    assign grant = rr_pick(req_valid, last_q);

    adder #(
        .DATA_WIDTH (DATA_WIDTH),
        .LENGTH     (LENGTH),
        .SUM_METHOD (SUM_METHOD)
    ) u_adder (
        .clk        (clk),
        .rst        (rst),
        .sum_en     (sum_en),
        .data       (opnd_q),
        .sum_result (sum_result),
        .sum_done   (sum_done)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        opnd_d    = opnd_q;
        rsp_sum_d = rsp_sum_q;
        rsp_id_d  = rsp_id_q;
        base_d    = base_q;
        req_ready = '0;
        sum_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    // gated so req_ready reads 0 while reset is held
                    req_ready[grant] = !rst;
                    opnd_d           = req_data[grant];
                    last_d           = grant;
                    state_d          = RUN;
                end
            end
            RUN: begin
                sum_en = 1'b1;
                if (sum_done) begin
                    // sequential accumulator keeps a running total; subtract the
                    // total seen at the previous capture to isolate this job
                    rsp_sum_d = sum_result - ((SUM_METHOD == SUM_SEQUENTIAL) ? base_q : '0);
                    base_d    = sum_result;
                    rsp_id_d  = last_q;
                    state_d   = RESP;
                end
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= IDW'(NUM_REQ - 1);
            opnd_q    <= '0;
            rsp_sum_q <= '0;
            rsp_id_q  <= '0;
            base_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            opnd_q    <= opnd_d;
            rsp_sum_q <= rsp_sum_d;
            rsp_id_q  <= rsp_id_d;
            base_q    <= base_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed + randomized checks of adder_arbiter against a sum/round-robin model.
module tb_adder_arbiter;

    localparam int N  = 4;
    localparam int L  = 8;
    localparam int DW = 32;
    localparam int SW = 35;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]               req_valid, req_ready, req_valid0, req_ready0;
    logic [N-1:0][L-1:0][DW-1:0] req_data, req_data0;
    logic                       rsp_valid, rsp_ready, busy;
    logic                       rsp_valid0, rsp_ready0, busy0;
    logic [1:0]                 rsp_id, rsp_id0;
    logic [SW-1:0]              rsp_sum, rsp_sum0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int m_last      = N - 1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .LENGTH(L), .SUM_METHOD(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy));

    adder_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .LENGTH(L), .SUM_METHOD(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_data(req_data0),
        .req_ready(req_ready0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_id(rsp_id0), .rsp_sum(rsp_sum0), .busy(busy0));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SW-1:0] vsum(input logic [L-1:0][DW-1:0] v);
        longint s = 0;
        for (int i = 0; i < L; i++) s += longint'(v[i]);
        return SW'(s);
    endfunction

    function automatic int rr_model(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic logic [L-1:0][DW-1:0] seq_vec();
        logic [L-1:0][DW-1:0] v;
        for (int i = 0; i < L; i++) v[i] = DW'(i + 1);
        return v;
    endfunction

    function automatic logic [L-1:0][DW-1:0] rnd_vec();
        logic [L-1:0][DW-1:0] v;
        for (int i = 0; i < L; i++) v[i] = $urandom;
        return v;
    endfunction

    task automatic wait_grant(output int g, output int c);
        int k = 0;
        int e;
        g = 0;
        while (req_ready === '0 && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        chk("grant_seen", {63'd0, |req_ready}, 64'd1);
        e = rr_model(req_valid, m_last);
        chk("req_ready", {60'd0, req_ready}, (e >= 0) ? (64'd1 << e) : 64'd0);
        chk("busy_idle", {63'd0, busy}, 64'd0);
        for (int i = N - 1; i >= 0; i--) if (req_ready[i]) g = i;
        c = cyc;
        if (e >= 0) m_last = e;
    endtask

    task automatic wait_rsp(input int c, input int lat, input int id, input logic [SW-1:0] e,
                            input int stall);
        int k = 0;
        while (rsp_valid !== 1'b1 && k < 60) begin
            @(negedge clk); #1;
            k++;
        end
        chk("rsp_seen", {63'd0, rsp_valid}, 64'd1);
        chk("latency", 64'(cyc - c), 64'(lat));
        chk("rsp_id", {62'd0, rsp_id}, 64'(id));
        chk("rsp_sum", {29'd0, rsp_sum}, {29'd0, e});
        chk("busy_resp", {63'd0, busy}, 64'd1);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk); #1;
            chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
            chk("hold_sum", {29'd0, rsp_sum}, {29'd0, e});
            chk("hold_id", {62'd0, rsp_id}, 64'(id));
            chk("hold_ready", {60'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("rsp_cleared", {63'd0, rsp_valid}, 64'd0);
    endtask

    task automatic job(input int r, input logic [L-1:0][DW-1:0] v);
        int g, c;
        @(negedge clk);
        req_data[r]  = v;
        req_valid[r] = 1'b1;
        #1;
        wait_grant(g, c);
        chk("grant_id", 64'(g), 64'(r));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("ready_run", {60'd0, req_ready}, 64'd0);
        wait_rsp(c, L + 2, r, vsum(v), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        #1;
        m_last = N - 1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int g, c, cnt[N];
        logic [SW-1:0] e;
        logic [L-1:0][DW-1:0] v;
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        rsp_ready  = 1'b0;
        req_valid0 = '0;
        req_data0  = '0;
        rsp_ready0 = 1'b0;
        @(negedge clk); #1;
        chk("rst_ready", {60'd0, req_ready}, 64'd0);
        chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_id", {62'd0, rsp_id}, 64'd0);
        chk("rst_sum", {29'd0, rsp_sum}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;

        // first request after reset goes to requester 0
        job(0, rnd_vec());
        job(2, seq_vec());

        // base correction across consecutive jobs of one requester
        job(1, seq_vec());
        job(1, {L{32'd5}});
        job(1, {L{32'hFFFF_FFFF}});

        // stalled response, a competing request waiting
        @(negedge clk);
        v            = rnd_vec();
        req_data[3]  = v;
        req_valid[3] = 1'b1;
        #1;
        wait_grant(g, c);
        chk("grant_s5", 64'(g), 64'd3);
        @(negedge clk);
        req_valid    = '0;
        req_data[0]  = rnd_vec();
        req_valid[0] = 1'b1;
        #1;
        wait_rsp(c, L + 2, 3, vsum(v), 5);
        chk("accept_after_hs", {60'd0, req_ready}, 64'd1);
        e = vsum(req_data[0]);
        wait_grant(g, c);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(c, L + 2, 0, e, 0);

        // reset in the middle of RUN
        @(negedge clk);
        req_data[1]  = rnd_vec();
        req_valid[1] = 1'b1;
        #1;
        wait_grant(g, c);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_busy", {63'd0, busy}, 64'd0);
        chk("mid_valid", {63'd0, rsp_valid}, 64'd0);
        chk("mid_sum", {29'd0, rsp_sum}, 64'd0);
        chk("mid_id", {62'd0, rsp_id}, 64'd0);
        m_last = N - 1;
        @(negedge clk);
        rst = 1'b0;
        job(1, seq_vec());

        // all requesters held valid: strict rotation
        do_reset();
        for (int i = 0; i < N; i++) begin
            cnt[i]      = 0;
            req_data[i] = rnd_vec();
        end
        @(negedge clk);
        req_valid = '1;
        #1;
        for (int j = 0; j < 2 * N; j++) begin
            wait_grant(g, c);
            chk("rr_order", 64'(g), 64'(j % N));
            cnt[g] = cnt[g] + 1;
            e = vsum(req_data[g]);
            @(negedge clk);
            req_data[g] = rnd_vec();
            #1;
            wait_rsp(c, L + 2, g, e, 0);
        end
        for (int i = 0; i < N; i++) chk("rr_fair", 64'(cnt[i]), 64'd2);
        req_valid = '0;

        // random request masks, others withdrawn after each grant
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) req_data[i] = rnd_vec();
            req_valid = N'($urandom_range(1, (1 << N) - 1));
            #1;
            wait_grant(g, c);
            e = vsum(req_data[g]);
            @(negedge clk);
            req_valid = '0;
            #1;
            wait_rsp(c, L + 2, g, e, 0);
        end

        // combinational adder variant
        @(negedge clk);
        req_data0[2]  = seq_vec();
        req_valid0[2] = 1'b1;
        #1;
        chk("m0_ready", {60'd0, req_ready0}, 64'h4);
        c = cyc;
        @(negedge clk);
        req_valid0 = '0;
        #1;
        chk("m0_busy", {63'd0, busy0}, 64'd1);
        chk("m0_early", {63'd0, rsp_valid0}, 64'd0);
        @(negedge clk); #1;
        chk("m0_valid", {63'd0, rsp_valid0}, 64'd1);
        chk("m0_latency", 64'(cyc - c), 64'd2);
        chk("m0_id", {62'd0, rsp_id0}, 64'd2);
        chk("m0_sum", {29'd0, rsp_sum0}, 64'd36);
        rsp_ready0 = 1'b1;
        @(negedge clk);
        rsp_ready0 = 1'b0;
        #1;
        chk("m0_done", {63'd0, busy0}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
